// File: rtl/hc_pkg.sv
// Shared constants and channel state type for the hc_debounce input stage.
package hc_pkg;

    localparam int unsigned HC_NCH       = 8;
    localparam int unsigned HC_DB_CYCLES = 50000;
    localparam int unsigned HC_CNT_W     = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } hc_state_t;

endpackage

// File: rtl/hc_db_bit.sv
// One debounce channel: 2-flop synchroniser, stability counter and IDLE/COUNT FSM.
// Optional change flag (chg) exists only when HC_DEBOUNCE_EDGE_EN is defined.
module hc_db_bit
    import hc_pkg::*;
#(
    parameter int unsigned DB_CYCLES = HC_DB_CYCLES,
    parameter int unsigned CNT_W     = HC_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
`ifdef HC_DEBOUNCE_EDGE_EN
    output logic chg,
`endif
    output logic level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1, s2;
    hc_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // A single-cycle threshold skips COUNT and copies s2 straight from IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            IDLE: begin
                if (s2 != level_q) begin
                    if (DB_CYCLES == 1) begin
                        level_d = s2;
                    end else begin
                        state_d = COUNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            COUNT: begin
                if (s2 == level_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = s2;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign level = level_q;

`ifdef HC_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg <= 1'b0;
        end else begin
            chg <= (level_d != level_q);
        end
    end
`endif

endmodule

// File: rtl/hc_debounce.sv
// Eight independent debounce channels feeding the quad OR stage A/B inputs.
// EDGE change-pulse port present only when HC_DEBOUNCE_EDGE_EN is defined.
module hc_debounce
    import hc_pkg::*;
#(
    parameter int unsigned DB_CYCLES = HC_DB_CYCLES,
    parameter int unsigned CNT_W     = HC_CNT_W
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:1] RAW_A,
    input  logic [4:1] RAW_B,
    output logic [4:1] A,
    output logic [4:1] B
`ifdef HC_DEBOUNCE_EDGE_EN
    ,
    output logic [7:0] EDGE
`endif
);

    logic [HC_NCH-1:0] raw_all;
    logic [HC_NCH-1:0] level_all;
`ifdef HC_DEBOUNCE_EDGE_EN
    logic [HC_NCH-1:0] chg_all;
`endif

    // Bits [3:0] carry A[4:1], bits [7:4] carry B[4:1].
    assign raw_all = {RAW_B, RAW_A};

    for (genvar i = 0; i < HC_NCH; i++) begin : g_ch
        hc_db_bit #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_bit (
            .clk  (CLK),
            .rst  (RST),
            .raw  (raw_all[i]),
`ifdef HC_DEBOUNCE_EDGE_EN
            .chg  (chg_all[i]),
`endif
            .level(level_all[i])
        );
    end

    assign A = level_all[3:0];
    assign B = level_all[7:4];

`ifdef HC_DEBOUNCE_EDGE_EN
    assign EDGE = chg_all;
`endif

endmodule
